// File: rtl/sub_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial_if
// Description : Handshake/data bundle for the digit-serial subtractor.
//               Operand side : in_valid, in_ready, a, b, sign
//               Result side  : out_valid, out_ready, s, v, z, n
//               master = producer of operands / consumer of results
//               slave  = the subtractor itself
// Revision    : 1.0  initial release
// ============================================================================
interface sub_serial_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             v;
  logic             z;
  logic             n;

  modport master (
    output in_valid, a, b, sign, out_ready,
    input  in_ready, out_valid, s, v, z, n
  );

  modport slave (
    input  in_valid, a, b, sign, out_ready,
    output in_ready, out_valid, s, v, z, n
  );
endinterface
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial
// Description : Digit-serial subtractor/comparator. Computes a-b at CHUNK
//               bits per clock (LSB chunk first), carrying the borrow between
//               chunks, and reports V (borrow/overflow), Z and N flags.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous reset, active low
//               bus    - sub_serial_if.slave (operand and result handshakes)
// Parameters  : WIDTH  - operand/result width (>= 2)
//               CHUNK  - bits per RUN cycle, WIDTH % CHUNK == 0
// Options     : SUB_SERIAL_SAT_EN - saturate s when v=1 (z follows the
//               saturated value, v/n keep the raw condition)
// Revision    : 1.0  initial release
// ============================================================================
module sub_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sub_serial_if.slave bus
);

  localparam int c_K  = WIDTH / CHUNK;
  localparam int c_CW = (c_K > 1) ? $clog2(c_K) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_K - 1);
  localparam int c_MSB = WIDTH - 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("sub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sign;
  logic [WIDTH-1:0] r_acc;     // working difference, filled chunk by chunk
  logic [c_CW-1:0]  r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_s;
  logic             r_v;
  logic             r_z;
  logic             r_n;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_diff;    // top bit is the borrow out of this chunk
  logic [WIDTH-1:0] w_acc_full;
  logic [WIDTH-1:0] w_s_final;
  logic             w_last;
  logic             w_v;
  logic             w_n;
  logic             w_z;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  assign w_last = (r_cnt == c_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)        w_state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.s         = r_s;
  assign bus.v         = r_v;
  assign bus.z         = r_z;
  assign bus.n         = r_n;

  // --------------------------------------------------------------------------
  // Chunk subtract and final-flag evaluation. The flags are only consumed on
  // the edge that processes the last chunk, so they are formed from the
  // fully assembled difference including the chunk being computed now.
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_chunk  = r_a[int'(r_cnt) * CHUNK +: CHUNK];
    w_b_chunk  = r_b[int'(r_cnt) * CHUNK +: CHUNK];
    w_diff     = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};
    w_acc_full = r_acc;
    w_acc_full[int'(r_cnt) * CHUNK +: CHUNK] = w_diff[CHUNK-1:0];

    if (r_sign) begin
      // Overflow only possible when operand signs differ and the result sign
      // disagrees with the minuend.
      w_v = (r_a[c_MSB] != r_b[c_MSB]) && (w_acc_full[c_MSB] != r_a[c_MSB]);
      w_n = w_acc_full[c_MSB] ^ w_v;
    end else begin
      w_v = w_diff[CHUNK];
      w_n = w_diff[CHUNK];
    end

    w_s_final = w_acc_full;
`ifdef SUB_SERIAL_SAT_EN
    if (w_v) begin
      if (r_sign) begin
        w_s_final = r_a[c_MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        w_s_final = '0;
      end
    end
`endif
    w_z = (w_s_final == '0);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_s      <= '0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_sign   <= bus.sign;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_full;
          r_borrow <= w_diff[CHUNK];
          if (w_last) begin
            r_cnt <= '0;
            r_s   <= w_s_final;
            r_v   <= w_v;
            r_z   <= w_z;
            r_n   <= w_n;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_serial
// Description : Self-checking bench for sub_serial. Three instances share the
//               same stimulus: CHUNK=8 (K=4), CHUNK=32 (K=1), CHUNK=1 (K=32).
//               Expected results come from a 33-bit reference model and are
//               queued at the input handshake, then popped at the result.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sub_serial;

  localparam int c_W = 32;
  localparam int c_NI = 3;

  typedef struct {
    logic [31:0] s;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sign;

  logic        ov [c_NI];
  logic        ir [c_NI];
  logic [31:0] so [c_NI];
  logic        vo [c_NI];
  logic        zo [c_NI];
  logic        no [c_NI];

  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  int c_KS [c_NI] = '{4, 1, 32};

  sub_serial_if #(.WIDTH(c_W)) bus [c_NI] ();

  generate
    for (genvar gi = 0; gi < c_NI; gi++) begin : g_dut
      assign bus[gi].in_valid  = in_valid;
      assign bus[gi].a         = a;
      assign bus[gi].b         = b;
      assign bus[gi].sign      = sign;
      assign bus[gi].out_ready = out_ready;
      assign ov[gi] = bus[gi].out_valid;
      assign ir[gi] = bus[gi].in_ready;
      assign so[gi] = bus[gi].s;
      assign vo[gi] = bus[gi].v;
      assign zo[gi] = bus[gi].z;
      assign no[gi] = bus[gi].n;
      sub_serial #(
        .WIDTH (c_W),
        .CHUNK ((gi == 0) ? 8 : (gi == 1) ? 32 : 1)
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[u%0d]: observed %h expected %h", tag, inst, obs, exp);
    end
  endtask

  // Reference: 33-bit infinite-precision style difference.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    exp_t e;
    logic [32:0] full;
    if (ts) begin
      full = {ta[31], ta} - {tb[31], tb};
      e.v  = full[32] ^ full[31];
      e.n  = full[32];
    end else begin
      full = {1'b0, ta} - {1'b0, tb};
      e.v  = full[32];
      e.n  = full[32];
    end
    e.s = full[31:0];
`ifdef SUB_SERIAL_SAT_EN
    if (e.v) e.s = ts ? (ta[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0;
`endif
    e.z = (e.s == 32'h0);
    return e;
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       input int hold, input bit toggle);
    exp_t e;
    int lat [c_NI];
    int c;
    q.push_back(model(ta, tb, ts));
    a = ta; b = tb; sign = ts; in_valid = 1'b1;
    for (int i = 0; i < c_NI; i++) chk("in_ready_idle", i, 32'(ir[i]), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < c_NI; i++) chk("out_valid_after_hs", i, 32'(ov[i]), 32'd0);
    chk("in_ready_run", 0, 32'(ir[0]), 32'd0);
    if (toggle) begin a = $urandom; b = $urandom; sign = ~sign; end
    for (int i = 0; i < c_NI; i++) lat[i] = 0;
    c = 0;
    while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (toggle) begin a = $urandom; b = $urandom; end
      for (int i = 0; i < c_NI; i++) if (lat[i] == 0 && ov[i]) lat[i] = c;
    end
    for (int i = 0; i < c_NI; i++) chk("latency", i, 32'(lat[i]), 32'(c_KS[i]));
    e = q.pop_front();
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;            // must be ignored in DONE
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_out_valid", 0, 32'(ov[0]), 32'd1);
      chk("hold_in_ready", 0, 32'(ir[0]), 32'd0);
      chk("hold_s", 0, so[0], e.s);
    end
    in_valid = 1'b0;
    for (int i = 0; i < c_NI; i++) begin
      chk("s", i, so[i], e.s);
      chk("v", i, 32'(vo[i]), 32'(e.v));
      chk("z", i, 32'(zo[i]), 32'(e.z));
      chk("n", i, 32'(no[i]), 32'(e.n));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < c_NI; i++) begin
      chk("out_valid_after_pop", i, 32'(ov[i]), 32'd0);
      chk("in_ready_after_pop", i, 32'(ir[i]), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sign = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    for (int i = 0; i < c_NI; i++) begin
      chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_s", i, so[i], 32'd0);
      chk("rst_flags", i, {29'd0, vo[i], zo[i], no[i]}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < c_NI; i++) chk("rst_in_ready", i, 32'(ir[i]), 32'd1);

    do_op(32'd5, 32'd7, 1'b0, 0, 1'b0);
    do_op(32'h8000_0000, 32'd1, 1'b1, 0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    do_op(32'h0000_1234, 32'h0000_1234, 1'b1, 0, 1'b0);
    do_op(32'h0000_1234, 32'h0000_1234, 1'b0, 0, 1'b0);
    do_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0, 1'b0);   // borrow ripples across chunks
    do_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0, 1'b0);
    for (int r = 0; r < 4; r++) do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0);
    do_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 10, 1'b1);  // backpressure + operand churn

    // Abort in RUN: reset must clear held outputs of every instance at once.
    a = 32'd5; b = 32'd7; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < c_NI; i++) begin
      chk("abort_out_valid", i, 32'(ov[i]), 32'd0);
      chk("abort_s", i, so[i], 32'd0);
      chk("abort_flags", i, {29'd0, vo[i], zo[i], no[i]}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < c_NI; i++) chk("abort_in_ready", i, 32'(ir[i]), 32'd1);
    do_op(32'd9, 32'd3, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sub_serial.md
Name: sub_serial

Overview:
Parametrised, digit-serial subtractor and comparator for the ALU. It computes A-B at CHUNK bits per clock, with the borrow carried between chunks in a register. It supports signed and unsigned modes and reports overflow/borrow (V), zero (Z) and negative/less-than (N) flags. It sits beside the combinational subtract path and is used where area matters more than latency. Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 32, operand and result width in bits; must be at least 2.
CHUNK, 8, bits processed per RUN cycle; WIDTH % CHUNK must equal 0, otherwise elaboration fails. K = WIDTH/CHUNK.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous reset, active low.
in_valid  input  1  operands a, b and sign are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  minuend; sampled only at input handshake.
b  input  WIDTH  subtrahend; sampled only at input handshake.
sign  input  1  1 = signed (two's complement), 0 = unsigned; sampled at handshake.
out_valid  output  1  s, v, z and n are valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
s  output  WIDTH  difference a-b, modulo 2^WIDTH.
v  output  1  unsigned: borrow (a<b); signed: two's-complement overflow.
z  output  1  s == 0.
n  output  1  unsigned: a<b; signed: true sign of the infinite-precision difference (s[WIDTH-1] XOR v).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, chunk counter=0, borrow=0, s=0, v=0, z=0, n=0, out_valid=0, in_ready=1 after release.
- States are IDLE, RUN and DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1: latch a, b and sign; clear borrow; counter=0; go to RUN.
- RUN: in_ready=0, out_valid=0.
  - On each edge, chunk i = counter (LSB chunk first) computes a_i - b_i - borrow, writes result bits [i*CHUNK +: CHUNK] of s, updates borrow, and increments the counter.
  - After the edge that processes chunk K-1, go to DONE.
- DONE entry flags:
  - Unsigned: v = final borrow; n = final borrow.
  - Signed: v = (a[MSB] != b[MSB]) AND (s[MSB] != a[MSB]); n = s[MSB] ^ v.
  - z = (s == 0), evaluated on the final s.
- Latency: out_valid rises exactly K cycles after the input-handshake edge. For WIDTH=32 and CHUNK=8 that is 4 cycles; for CHUNK=WIDTH it is 1 cycle.
- DONE: out_valid=1, and s, v, z, n are held stable for as long as out_ready=0.
  - On an edge with out_ready=1: go to IDLE; out_valid=0 on the next cycle.
  - Outputs keep their last values in IDLE and RUN. They are only guaranteed while out_valid=1.
- No same-cycle turnaround: a new operand cannot be accepted in the cycle the result is consumed. Back-to-back throughput is one result per K+2 cycles.
- Changes on a, b or sign outside the input handshake have no effect.
- Reset asserted in RUN or DONE aborts the operation immediately to reset values. A pending result is lost.
- in_valid in RUN/DONE is ignored; no operand is captured. out_ready outside DONE is ignored.

Optional Feature:
SUB_SERIAL_SAT_EN:
- Defined: saturating result when v=1, applied at DONE entry.
  - Signed: s = 0x7FF..F if a is non-negative, else 0x800..0.
  - Unsigned: s = 0.
  - z is recomputed from the saturated s; v and n still report the unsaturated condition.
- Undefined: s always wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan:
- Unsigned, WIDTH=32, CHUNK=8: a=5, b=7, sign=0 -> out_valid exactly 4 cycles after handshake; s=0xFFFFFFFE, v=1, n=1, z=0.
- Signed: a=0x80000000, b=1 -> s=0x7FFFFFFF, v=1, n=1, z=0.
- Signed: a=0x7FFFFFFF, b=0xFFFFFFFF -> s=0x80000000, v=1, n=0. With SUB_SERIAL_SAT_EN: s=0x7FFFFFFF, z=0.
- Equal operands: a=b=0x00001234, sign=1, then the same with sign=0 -> s=0, z=1, v=0, n=0 in both modes.
- Backpressure and operand stability:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and s stay stable, in_ready=0.
  - Toggle a/b during RUN -> result unchanged.
  - Pulse out_ready -> IDLE, in_ready=1 next cycle.
- Reset and parameter variants:
  - Drop rst_n after RUN cycle 2 -> all outputs 0 immediately, state IDLE.
  - Next operation 9-3 gives s=6 with no stale borrow.
  - Repeat the first scenario with CHUNK=32 (latency 1) and CHUNK=1 (latency 32).
